// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
package pipe_ctrl_pkg;

  // Controller sequencing states: normal flow, or holding a divide in EX.
  typedef enum logic [0:0] {
    HZ_RUN = 1'b0,
    HZ_DIV = 1'b1
  } hz_state_e;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Instruction word a flushed IF/ID register holds (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Width of the divide cycle down-counter.
  localparam int          DIV_CNT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs and stage controls.
// master = pipeline datapath, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_wn;
  logic       ex_div_start;
  logic       mem_redirect;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_flush;
  logic       div_busy;
  logic       div_done;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wn,
           ex_div_start, mem_redirect,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_flush, div_busy, div_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wn,
           ex_div_start, mem_redirect,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_flush, div_busy, div_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Saturating event counter used for the optional hazard performance counters
// (PIPE_HAZARD_PERF_EN). Sticks at all-ones instead of wrapping.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count qualifying cycles, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use bubble,
// multi-cycle divide hold in EX, and squash on a MEM-stage redirect.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating stall/flush/divide counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
`ifdef PIPE_HAZARD_PERF_EN
  , output logic [CNT_W-1:0]   perf_stall_cnt
  , output logic [CNT_W-1:0]   perf_flush_cnt
  , output logic [CNT_W-1:0]   perf_div_cnt
`endif
);

  // The starting instruction counts as the first EX cycle, so load one less.
  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  hz_state_e            state_r;
  hz_state_e            next_state_s;
  logic [DIV_CNT_W-1:0] div_cnt_r;
  logic [DIV_CNT_W-1:0] next_cnt_s;
  logic                 load_use_s;

  logic pc_write_s;
  logic ifid_write_s;
  logic ifid_flush_s;
  logic idex_write_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic div_busy_s;
  logic div_done_s;

  // A load whose destination feeds the ID instruction needs one bubble; $0 never counts.
  assign load_use_s = hz.ex_memread && (hz.ex_wn != REG_ZERO) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_wn)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_wn)));

  // State and divide counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= HZ_RUN;
      div_cnt_r <= 8'd0;
    end else begin
      state_r   <= next_state_s;
      div_cnt_r <= next_cnt_s;
    end
  end

  // Next state and stage controls; redirect beats divide beats load-use.
  always_comb begin
    next_state_s  = state_r;
    next_cnt_s    = div_cnt_r;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_write_s  = 1'b1;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    div_busy_s    = 1'b0;
    div_done_s    = 1'b0;
    if (rst) begin
      // Hold idle controls for the whole reset, independent of the inputs.
      next_state_s = HZ_RUN;
      next_cnt_s   = 8'd0;
    end else if (hz.mem_redirect) begin
      // Squash everything younger than MEM; any divide in flight is abandoned.
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
      next_state_s  = HZ_RUN;
      next_cnt_s    = 8'd0;
    end else begin
      case (state_r)
        HZ_RUN: begin
          if (hz.ex_div_start) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_flush_s = 1'b1;
            div_busy_s    = 1'b1;
            next_cnt_s    = DIV_LOAD;
            next_state_s  = HZ_DIV;
          end else if (load_use_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            next_state_s = HZ_RUN;
          end
        end
        HZ_DIV: begin
          if (div_cnt_r > 8'd1) begin
            // Keep holding the same DIV in EX; its ex_div_start is not a new request.
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_flush_s = 1'b1;
            div_busy_s    = 1'b1;
            next_cnt_s    = div_cnt_r - 8'd1;
          end else begin
            // Final EX cycle: strobe Hi/Lo and let the DIV advance to MEM.
            div_busy_s   = 1'b1;
            div_done_s   = 1'b1;
            next_cnt_s   = 8'd0;
            next_state_s = HZ_RUN;
          end
        end
        default: begin
          next_state_s = HZ_RUN;
          next_cnt_s   = 8'd0;
        end
      endcase
    end
  end

  assign hz.pc_write    = pc_write_s;
  assign hz.ifid_write  = ifid_write_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.idex_write  = idex_write_s;
  assign hz.idex_flush  = idex_flush_s;
  assign hz.exmem_flush = exmem_flush_s;
  assign hz.div_busy    = div_busy_s;
  assign hz.div_done    = div_done_s;

`ifdef PIPE_HAZARD_PERF_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .inc (~pc_write_s),      .cnt (perf_stall_cnt)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (hz.mem_redirect),  .cnt (perf_flush_cnt)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_div_cnt (
    .clk (clk), .rst (rst), .inc (div_done_s),       .cnt (perf_div_cnt)
  );
`endif

endmodule
